// File: rtl/addseq_if.sv
// Command/result bundle between a command source and the addseq_ctrl sequencer.
// Optional sub line is present only when ADDSEQ_SUB_EN is defined.
interface addseq_if #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
);
  localparam int W = SIZE * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
`ifdef ADDSEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;

  modport master (
`ifdef ADDSEQ_SUB_EN
    output sub,
`endif
    output start, a, b, ci,
    input  busy, done, sum, co
  );

  modport slave (
`ifdef ADDSEQ_SUB_EN
    input  sub,
`endif
    input  start, a, b, ci,
    output busy, done, sum, co
  );
endinterface

// File: rtl/addseq_ctrl.sv
// Multi-word adder sequencer: one SIZE-bit adder stage reused per word, LSW first.
// Define ADDSEQ_SUB_EN to add the sub input (a - b with no-borrow carry-out).
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one word per cycle through the adder, carry registered between words
// DONE  | one cycle; done and co presented, start ignored
module addseq_ctrl #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input logic      clk,
  input logic      rst_n,
  addseq_if.slave  bus
);
  localparam int W  = SIZE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state_q, state_nx;
  logic [IW-1:0]                idx_q;
  logic                         carry_q;
  logic                         sub_q;
  logic [WORDS-1:0][SIZE-1:0]   a_q, b_q, sum_q;
  logic                         co_q, busy_q, done_q;
  logic                         busy_nx, done_nx;
  logic                         sub_in;
  logic [SIZE-1:0]              b_word;
  logic [SIZE:0]                add_r;

`ifdef ADDSEQ_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (idx_q == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so busy/done come straight off flops.
  always_comb begin
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  always_comb begin
    b_word = b_q[idx_q] ^ {SIZE{sub_q}};
    add_r  = {1'b0, a_q[idx_q]} + {1'b0, b_word} + {{SIZE{1'b0}}, carry_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= busy_nx;
      done_q <= done_nx;
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          sub_q   <= sub_in;
          // Subtraction is a + ~b + 1, so the initial carry is forced high.
          carry_q <= sub_in | bus.ci;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[idx_q] <= add_r[SIZE-1:0];
          carry_q      <= add_r[SIZE];
          idx_q        <= idx_q + IW'(1);
          if (idx_q == LAST) co_q <= add_r[SIZE];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = W'(sum_q);
  assign bus.co   = co_q;
endmodule

// File: tb/tb_addseq_ctrl.sv
// Directed bench for addseq_ctrl (SIZE=4, WORDS=4) with hand-computed results.
// Subtraction vectors run only when ADDSEQ_SUB_EN is defined.
module tb_addseq_ctrl;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat, bcnt, dcnt;
  logic [15:0] sum_at_done;

  addseq_if #(.SIZE(4), .WORDS(4)) bus ();
  addseq_ctrl #(.SIZE(4), .WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation, scrambles the live inputs, returns done latency and busy cycles.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        output int latency, output int busy_cycles);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.ci = civ;
    tick();
    bus.start = 1'b0; bus.a = 16'hA5A5; bus.b = 16'h5A5A; bus.ci = ~civ;
    latency = -1;
    busy_cycles = bus.busy ? 1 : 0;
    for (int k = 1; k <= 20 && latency < 0; k++) begin
      tick();
      if (bus.busy) busy_cycles++;
      if (bus.done) latency = k;
    end
    tick();
    if (bus.busy) busy_cycles++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
`ifdef ADDSEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    #22 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum",  bus.sum,  16'h0000);
    chk("rst_co",   bus.co,   0);

    // Carry across one word boundary; latency and busy length
    run_op(16'h00FF, 16'h0001, 1'b0, lat, bcnt);
    chk("t2_latency", lat, 4);
    chk("t2_busy_cycles", bcnt, 5);
    chk("t2_sum", bus.sum, 16'h0100);
    chk("t2_co", bus.co, 0);
    chk("t2_done_low", bus.done, 0);

    // Carry-in rippling through all words
    run_op(16'hFFFF, 16'h0000, 1'b1, lat, bcnt);
    chk("t3_latency", lat, 4);
    chk("t3_sum", bus.sum, 16'h0000);
    chk("t3_co", bus.co, 1);

    // Reset while in RUN with idx=2
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.ci = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("t5_partial_sum", bus.sum, 16'h0045);
    chk("t5_co_held", bus.co, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_sum", bus.sum, 16'h0000);
    chk("t5_co", bus.co, 0);
    #3 rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done || bus.busy) dcnt++;
    end
    chk("t5_no_activity", dcnt, 0);
    run_op(16'h0003, 16'h0004, 1'b0, lat, bcnt);
    chk("t5_after_latency", lat, 4);
    chk("t5_after_sum", bus.sum, 16'h0007);
    chk("t5_after_co", bus.co, 0);

    // start re-pulsed during RUN is ignored
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.ci = 1'b0;
    tick();
    bus.start = 1'b0; bus.a = 16'hFFFF;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dcnt = 0;
    sum_at_done = '0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) begin
        dcnt++;
        sum_at_done = bus.sum;
      end
      tick();
    end
    chk("t4_done_count", dcnt, 1);
    chk("t4_sum", sum_at_done, 16'h2345);
    chk("t4_idle", bus.busy, 0);

    // start during DONE is ignored
    bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.ci = 1'b0;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (bus.done) lat = k;
    end
    chk("done_latency", lat, 4);
    chk("done_sum", bus.sum, 16'h1010);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    tick();
    bus.start = 1'b0;
    chk("done_start_busy", bus.busy, 0);
    tick();
    chk("done_start_busy2", bus.busy, 0);
    chk("done_start_sum", bus.sum, 16'h1010);

    // Wrap past 2^16 with carry-out
    run_op(16'h8000, 16'h8001, 1'b0, lat, bcnt);
    chk("wrap_sum", bus.sum, 16'h0001);
    chk("wrap_co", bus.co, 1);

`ifdef ADDSEQ_SUB_EN
    bus.sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, lat, bcnt);
    chk("sub_neg_sum", bus.sum, 16'hFFFE);
    chk("sub_neg_co", bus.co, 0);
    run_op(16'h0007, 16'h0005, 1'b0, lat, bcnt);
    chk("sub_pos_sum", bus.sum, 16'h0002);
    chk("sub_pos_co", bus.co, 1);
    bus.sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
